func_sweep_ctrl: RTL

//  Upstream stimulus and capture stage for the 3-input function decoder.
//  - Drives every input code 0..7 onto the decoder input in turn.
//  - Waits a settle interval, then samples F[3:1].
//  - Builds one 8-bit minterm mask per output; mask bit k = value of that output when the input was k.
//  - Flags a consistency error when F3 != F1|F2.
//  - Reports done. Used on the lab board to read back the implemented truth table.

---
 rtl/func_sweep_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/func_sweep_ctrl.sv
// func_sweep_ctrl: drives input codes 0..7 to a 3-input function decoder.
// Each code is held for SETTLE+1 cycles. F[3:1] is sampled on the last cycle.
// The samples build one 8-bit minterm mask per output, and a sticky flag is
// raised whenever F3 != F1|F2.
module func_sweep_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] f_in,
    output logic [2:0] i_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] f1_mask,
    output logic [7:0] f2_mask,
    output logic [7:0] f3_mask,
    output logic       err
);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_t;

    // Counter reload; a code is held SETTLE cycles in StSettle plus one in StSample.
    localparam logic [3:0] LP_RELOAD = 4'(SETTLE - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [2:0] r_code;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_f1;
    logic [7:0] r_f2;
    logic [7:0] r_f3;
    logic       r_err;

    logic       w_mismatch;

    assign w_mismatch = f_in[2] != (f_in[0] | f_in[1]);

    // Sweep FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_code  <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_f1    <= 8'h00;
            r_f2    <= 8'h00;
            r_f3    <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state <= StSettle;
                        r_cnt   <= LP_RELOAD;
                        r_code  <= 3'd0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_f1    <= 8'h00;
                        r_f2    <= 8'h00;
                        r_f3    <= 8'h00;
                        r_err   <= 1'b0;
                    end
                end
                StSettle: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= StSample;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StSample: begin
                    r_f1[r_code] <= f_in[0];
                    r_f2[r_code] <= f_in[1];
                    r_f3[r_code] <= f_in[2];
                    if (w_mismatch) begin
                        r_err <= 1'b1;
                    end
                    if (r_code == 3'd7) begin
                        // Code stays at 7 in StDone; it never wraps.
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_code  <= r_code + 3'd1;
                        r_cnt   <= LP_RELOAD;
                        r_state <= StSettle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign i_out   = r_code;
    assign busy    = r_busy;
    assign done    = r_done;
    assign f1_mask = r_f1;
    assign f2_mask = r_f2;
    assign f3_mask = r_f3;
    assign err     = r_err;

endmodule
